// File: rtl/id_ex_pipeline_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_reg_pkg
// Shared encodings for the ID/EX pipeline register:
//   - control-field widths (ALU_OP_W, SEL_W)
//   - BUBBLE_* values: what each control field holds when a bubble sits in EX
//   - sat_inc32: saturating 32-bit increment used by the optional counters
// -----------------------------------------------------------------------------
package id_ex_pipeline_reg_pkg;

   localparam int ALU_OP_W = 5;
   localparam int SEL_W    = 2;

   localparam logic                BUBBLE_VALID        = 1'b0;
   localparam logic [ALU_OP_W-1:0] BUBBLE_ALU_OP       = '0;
   localparam logic [SEL_W-1:0]    BUBBLE_BRANCH_SEL   = '0;
   localparam logic                BUBBLE_USE_IMM      = 1'b0;
   localparam logic [SEL_W-1:0]    BUBBLE_MEM_WRITE    = '0;
   localparam logic [SEL_W-1:0]    BUBBLE_MEM_READ     = '0;
   localparam logic [SEL_W-1:0]    BUBBLE_WB_SEL       = '0;
   localparam logic                BUBBLE_REG_WRITE_EN = 1'b0;
   localparam logic                BUBBLE_IS_LOAD      = 1'b0;

   // Holds at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_load_use_detector.sv
// -----------------------------------------------------------------------------
// load_use_detector
// Combinational load-use hazard check between the load in EX and the
// instruction in ID.
//   i_ex_valid, i_ex_is_load, i_ex_rd_addr : instruction currently in EX
//   i_id_valid, i_id_rs1_addr, i_id_rs2_addr : instruction currently in ID
//   i_flush, i_mem_stall : suppress the stall (bubble/freeze wins anyway)
//   o_load_use_stall : hold PC and IF/ID, insert one bubble
// -----------------------------------------------------------------------------
module load_use_detector #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_ex_valid,
   input  logic                  i_ex_is_load,
   input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
   input  logic                  i_flush,
   input  logic                  i_mem_stall,
   output logic                  o_load_use_stall
);

   logic w_match;
   logic w_hazard;

   // Both sources are compared even if the ID instruction does not read rs2;
   // a spurious bubble is cheaper than decoding operand usage here.
   assign w_match  = (i_ex_rd_addr == i_id_rs1_addr) | (i_ex_rd_addr == i_id_rs2_addr);
   assign w_hazard = i_ex_valid & i_ex_is_load & i_id_valid &
                     (i_ex_rd_addr != '0) & w_match;

   // A flush kills the ID instruction, and a memory freeze holds everything,
   // so holding upstream would only lose a cycle.
   assign o_load_use_stall = w_hazard & ~i_flush & ~i_mem_stall;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_reg
// Pipeline register between ID/RF and EX, with the load-use hazard detector.
//   clk, reset_n (async, active-low)
//   mem_stall      : freeze every ex_* register
//   flush          : load a bubble (branch/jump taken in EX)
//   id_*           : decoded fields and operands from ID
//   load_use_stall : combinational; holds PC and IF/ID for one cycle
//   ex_*           : registered EX-stage copies of the id_* fields
// Optional (macro ID_EX_STALL_CNT_EN): bubble_cnt, load_use_cnt saturating
// event counters.
// -----------------------------------------------------------------------------
module id_ex_pipeline_reg
   import id_ex_pipeline_reg_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mem_stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic [SEL_W-1:0]      id_branch_sel,
   input  logic                  id_use_imm,
   input  logic [SEL_W-1:0]      id_mem_write,
   input  logic [SEL_W-1:0]      id_mem_read,
   input  logic [SEL_W-1:0]      id_write_back_sel,
   input  logic                  id_reg_write_en,
   input  logic                  id_is_load,
   output logic                  load_use_stall,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_rs1_data,
   output logic [XLEN-1:0]       ex_rs2_data,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs1_addr,
   output logic [REG_ADDR_W-1:0] ex_rs2_addr,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic [SEL_W-1:0]      ex_branch_sel,
   output logic                  ex_use_imm,
   output logic [SEL_W-1:0]      ex_mem_write,
   output logic [SEL_W-1:0]      ex_mem_read,
   output logic [SEL_W-1:0]      ex_write_back_sel,
   output logic                  ex_reg_write_en,
   output logic                  ex_is_load
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0]           bubble_cnt,
   output logic [31:0]           load_use_cnt
`endif
);

   logic                  r_valid;
   logic [XLEN-1:0]       r_pc;
   logic [XLEN-1:0]       r_rs1_data;
   logic [XLEN-1:0]       r_rs2_data;
   logic [XLEN-1:0]       r_imm;
   logic [REG_ADDR_W-1:0] r_rs1_addr;
   logic [REG_ADDR_W-1:0] r_rs2_addr;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic [ALU_OP_W-1:0]   r_alu_op;
   logic [SEL_W-1:0]      r_branch_sel;
   logic                  r_use_imm;
   logic [SEL_W-1:0]      r_mem_write;
   logic [SEL_W-1:0]      r_mem_read;
   logic [SEL_W-1:0]      r_wb_sel;
   logic                  r_reg_write_en;
   logic                  r_is_load;

   logic w_load_use_stall;
   logic w_bubble;

   load_use_detector #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detector (
      .i_ex_valid       (r_valid),
      .i_ex_is_load     (r_is_load),
      .i_ex_rd_addr     (r_rd_addr),
      .i_id_valid       (id_valid),
      .i_id_rs1_addr    (id_rs1_addr),
      .i_id_rs2_addr    (id_rs2_addr),
      .i_flush          (flush),
      .i_mem_stall      (mem_stall),
      .o_load_use_stall (w_load_use_stall)
   );

   assign w_bubble = flush | w_load_use_stall;

   // Priority: freeze > flush/hazard bubble > capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid        <= BUBBLE_VALID;
         r_pc           <= '0;
         r_rs1_data     <= '0;
         r_rs2_data     <= '0;
         r_imm          <= '0;
         r_rs1_addr     <= '0;
         r_rs2_addr     <= '0;
         r_rd_addr      <= '0;
         r_alu_op       <= BUBBLE_ALU_OP;
         r_branch_sel   <= BUBBLE_BRANCH_SEL;
         r_use_imm      <= BUBBLE_USE_IMM;
         r_mem_write    <= BUBBLE_MEM_WRITE;
         r_mem_read     <= BUBBLE_MEM_READ;
         r_wb_sel       <= BUBBLE_WB_SEL;
         r_reg_write_en <= BUBBLE_REG_WRITE_EN;
         r_is_load      <= BUBBLE_IS_LOAD;
      end else if (!mem_stall) begin
         if (w_bubble) begin
            r_valid        <= BUBBLE_VALID;
            r_pc           <= '0;
            r_rs1_data     <= '0;
            r_rs2_data     <= '0;
            r_imm          <= '0;
            r_rs1_addr     <= '0;
            r_rs2_addr     <= '0;
            r_rd_addr      <= '0;
            r_alu_op       <= BUBBLE_ALU_OP;
            r_branch_sel   <= BUBBLE_BRANCH_SEL;
            r_use_imm      <= BUBBLE_USE_IMM;
            r_mem_write    <= BUBBLE_MEM_WRITE;
            r_mem_read     <= BUBBLE_MEM_READ;
            r_wb_sel       <= BUBBLE_WB_SEL;
            r_reg_write_en <= BUBBLE_REG_WRITE_EN;
            r_is_load      <= BUBBLE_IS_LOAD;
         end else begin
            r_valid        <= id_valid;
            r_pc           <= id_pc;
            r_rs1_data     <= id_rs1_data;
            r_rs2_data     <= id_rs2_data;
            r_imm          <= id_imm;
            r_rs1_addr     <= id_rs1_addr;
            r_rs2_addr     <= id_rs2_addr;
            r_rd_addr      <= id_rd_addr;
            r_alu_op       <= id_alu_op;
            r_use_imm      <= id_use_imm;
            r_wb_sel       <= id_write_back_sel;
            // Decode may assert side-effecting controls for garbage opcodes;
            // they only pass through with a real instruction.
            r_branch_sel   <= id_valid ? id_branch_sel   : BUBBLE_BRANCH_SEL;
            r_mem_write    <= id_valid ? id_mem_write    : BUBBLE_MEM_WRITE;
            r_mem_read     <= id_valid ? id_mem_read     : BUBBLE_MEM_READ;
            r_reg_write_en <= id_valid ? id_reg_write_en : BUBBLE_REG_WRITE_EN;
            r_is_load      <= id_valid ? id_is_load      : BUBBLE_IS_LOAD;
         end
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] r_bubble_cnt;
   logic [31:0] r_load_use_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bubble_cnt   <= '0;
         r_load_use_cnt <= '0;
      end else if (!mem_stall) begin
         if (w_bubble)         r_bubble_cnt   <= sat_inc32(r_bubble_cnt);
         if (w_load_use_stall) r_load_use_cnt <= sat_inc32(r_load_use_cnt);
      end
   end

   assign bubble_cnt   = r_bubble_cnt;
   assign load_use_cnt = r_load_use_cnt;
`endif

   assign load_use_stall    = w_load_use_stall;
   assign ex_valid          = r_valid;
   assign ex_pc             = r_pc;
   assign ex_rs1_data       = r_rs1_data;
   assign ex_rs2_data       = r_rs2_data;
   assign ex_imm            = r_imm;
   assign ex_rs1_addr       = r_rs1_addr;
   assign ex_rs2_addr       = r_rs2_addr;
   assign ex_rd_addr        = r_rd_addr;
   assign ex_alu_op         = r_alu_op;
   assign ex_branch_sel     = r_branch_sel;
   assign ex_use_imm        = r_use_imm;
   assign ex_mem_write      = r_mem_write;
   assign ex_mem_read       = r_mem_read;
   assign ex_write_back_sel = r_wb_sel;
   assign ex_reg_write_en   = r_reg_write_en;
   assign ex_is_load        = r_is_load;

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- Pipeline register between the ID/RF stage (control decode, register file, immediate generator) and the EX stage.
- Captures decoded control fields and operands each cycle. Inserts bubbles on flush or load-use hazard, and freezes on a memory stall.
- Contains the load-use hazard detector. It drives the stall that holds PC and IF/ID.

Parameters:
XLEN, 32, datapath width of pc/operands/immediate
REG_ADDR_W, 5, register-index width

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
mem_stall  input  1  downstream memory busy; freeze this register
flush  input  1  taken branch/jump resolved in EX; kill the ID instruction
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  PC of the ID instruction
id_rs1_data  input  XLEN  register-file read data 1
id_rs2_data  input  XLEN  register-file read data 2
id_imm  input  XLEN  generated immediate
id_rs1_addr  input  REG_ADDR_W  source index 1
id_rs2_addr  input  REG_ADDR_W  source index 2
id_rd_addr  input  REG_ADDR_W  destination index
id_alu_op  input  5  ALU operation
id_branch_sel  input  2  branch/jump selector
id_use_imm  input  1  operand-B mux select
id_mem_write  input  2  store control
id_mem_read  input  2  load control
id_write_back_sel  input  2  write-back source
id_reg_write_en  input  1  register write enable
id_is_load  input  1  ID instruction is a load
load_use_stall  output  1  hold PC and IF/ID this cycle (combinational)
ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_alu_op, ex_branch_sel, ex_use_imm, ex_mem_write, ex_mem_read, ex_write_back_sel, ex_reg_write_en, ex_is_load  output  (same widths as id_ counterparts)  registered EX-stage copies

Behaviour:
- Clocking: one clock, clk. reset_n is asynchronous, active-low.
- Reset: while reset_n=0, every ex_* output is 0. Deasserting reset mid-operation resumes with a bubble in EX.
- Load-use hazard: load_use_stall = ex_valid & ex_is_load & id_valid & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Both sources are compared unconditionally (conservative).
  - load_use_stall is forced to 0 when flush=1 or mem_stall=1.
- Per-edge priority, highest first:
  1. mem_stall=1: hold all ex_* registers unchanged, including through flush or a hazard.
  2. flush=1: load a bubble.
  3. load_use_stall=1: load a bubble. Upstream holds ID, so the same instruction is re-presented next cycle.
  4. Otherwise: capture every id_* field; ex_valid <= id_valid.
- Bubble: all ex_* outputs 0, including ex_valid, ex_reg_write_en, ex_mem_read/write and ex_branch_sel.
- Invalid ID: id_valid=0 without a bubble condition still forces ex_reg_write_en, ex_mem_write, ex_mem_read, ex_branch_sel and ex_is_load to 0. Decode asserts reg_write_en for unknown opcodes, so these must never leak.
- Latency: 1 cycle, ID to EX. A load-use hazard costs exactly 1 bubble. The second cycle cannot re-hazard because EX then holds the bubble (ex_valid=0).
- Back-to-back loads into dependent instructions: each dependent instruction receives its own single bubble.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined: adds outputs bubble_cnt[31:0] and load_use_cnt[31:0].
  - bubble_cnt increments on every bubble insertion (flush or hazard).
  - load_use_cnt increments on hazard bubbles only.
  - Neither increments while mem_stall=1. Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and logic do not exist; behaviour is otherwise identical.

Decomposition:
- Shared constants go in the existing encodings include: BUBBLE_* zero values for each control field; field widths (ALU_OP_W=5, SEL_W=2).
- One sub-module: load_use_detector, purely combinational, generating load_use_stall. The register and priority logic stays in the top.

Test Plan:
- Reset: reset_n=0 mid-stream with ex_reg_write_en=1 -> all ex_* =0 immediately, asynchronously.
- Normal capture: id_pc=0x100, alu_op=5'b00000, rd=3, id_valid=1 -> next edge ex_pc=0x100, ex_rd_addr=3, ex_valid=1.
- Load-use: EX has lw x5 (ex_is_load=1, rd=5), ID add uses rs1=5 -> load_use_stall=1.
  - Next edge: ex_valid=0, ex_reg_write_en=0.
  - Following edge: the add is captured and load_use_stall=0.
- x0 and no-match: EX load with rd=0, or ID sources 6/7 -> load_use_stall=0; normal capture.
- Flush beats hazard: flush=1 while the load-use condition holds -> load_use_stall=0, a bubble is loaded, and ID is not held.
- Stall beats all: mem_stall=1 for 3 cycles with flush=1 -> ex_* unchanged across all 3 edges.
  - With ID_EX_STALL_CNT_EN defined: bubble_cnt does not change.
